systolic_array_os_param: RTL and testbench



---
 rtl/systolic_array_os_param.sv | 251 +++++++++++++++++++++++++
 tb/tb_systolic_array_os_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_os_param.sv
// Output-stationary ROWS x COLS signed matmul array with skewed operand feed,
// optional saturating accumulation and a non-destructive rotating column readout.
module systolic_array_os_param #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int K_W      = 20,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ROWS*DATA_W-1:0]  act_in,
  input  logic                    act_valid,
  output logic                    act_ready,
  input  logic [COLS*DATA_W-1:0]  wgt_in,
  input  logic                    wgt_valid,
  output logic                    wgt_ready,
  input  logic                    ctrl_start_valid,
  output logic                    ctrl_start_ready,
  input  logic [K_W-1:0]          ctrl_inner_dim,
  input  logic                    ctrl_accumulate,
  output logic [ROWS*ACC_W-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    SHIFT = 2'd3
  } state_t;

  localparam int DR_W   = $clog2(ROWS + COLS);
  localparam int BEAT_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [DR_W-1:0]   DRAIN_LAST = DR_W'(ROWS + COLS - 2);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(COLS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [K_W-1:0]      r_k;
  logic [K_W-1:0]      r_cnt;
  logic [DR_W-1:0]     r_drain;
  logic [BEAT_W-1:0]   r_beat;

  logic w_start;
  logic w_clear;
  logic w_beat;
  logic w_adv;
  logic w_shift_hs;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; ready never depends on the same channel's data. Activation
  // and weight beats transfer only jointly.
  assign w_start    = (r_state == IDLE) && ctrl_start_valid;
  assign w_clear    = w_start && !ctrl_accumulate;
  assign w_beat     = (r_state == LOAD) && act_valid && wgt_valid;
  assign w_adv      = w_beat || (r_state == DRAIN);
  assign w_shift_hs = (r_state == SHIFT) && out_ready;

  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    ctrl_start_ready = 1'b0;
    act_ready        = 1'b0;
    wgt_ready        = 1'b0;
    out_valid        = 1'b0;
    out_last         = 1'b0;
    case (r_state)
      IDLE: begin
        ctrl_start_ready = 1'b1;
        if (ctrl_start_valid)
          w_state_nxt = (ctrl_inner_dim != '0) ? LOAD : SHIFT;
      end
      LOAD: begin
        act_ready = act_valid && wgt_valid;
        wgt_ready = act_valid && wgt_valid;
        if (act_valid && wgt_valid && (r_cnt == r_k - K_W'(1)))
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_drain == DRAIN_LAST) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_last  = (r_beat == BEAT_LAST);
        if (out_ready && (r_beat == BEAT_LAST)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      r_beat  <= '0;
    end else begin
      if (w_start) begin
        r_k   <= ctrl_inner_dim;
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + K_W'(1);
      end
      if (r_state == DRAIN) r_drain <= r_drain + DR_W'(1);
      else                  r_drain <= '0;
      if (w_shift_hs)
        r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + BEAT_W'(1);
    end
  end

  // Operand wires entering each PE: act from the left, wgt from above.
  logic [DATA_W-1:0]            w_pe_a [ROWS][COLS];
  logic [DATA_W-1:0]            w_pe_w [ROWS][COLS];
  logic [ROWS-1:0][COLS-1:0]    w_pe_av;
  logic [ROWS-1:0][COLS-1:0]    w_pe_wv;

  for (genvar r = 0; r < ROWS; r++) begin : g_act_skew
    if (r == 0) begin : g_direct
      assign w_pe_a[r][0]  = act_in[DATA_W-1:0];
      assign w_pe_av[r][0] = w_beat;
    end else begin : g_delay
      logic [DATA_W-1:0] r_d [r];
      logic              r_v [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) r_v[i] <= 1'b0;
        end else if (w_adv) begin
          r_v[0] <= w_beat;
          for (int i = 1; i < r; i++) r_v[i] <= r_v[i-1];
        end
      end
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_d[0] <= act_in[r*DATA_W +: DATA_W];
          for (int i = 1; i < r; i++) r_d[i] <= r_d[i-1];
        end
      end
      assign w_pe_a[r][0]  = r_d[r-1];
      assign w_pe_av[r][0] = r_v[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wgt_skew
    if (c == 0) begin : g_direct
      assign w_pe_w[0][c]  = wgt_in[DATA_W-1:0];
      assign w_pe_wv[0][c] = w_beat;
    end else begin : g_delay
      logic [DATA_W-1:0] r_d [c];
      logic              r_v [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) r_v[i] <= 1'b0;
        end else if (w_adv) begin
          r_v[0] <= w_beat;
          for (int i = 1; i < c; i++) r_v[i] <= r_v[i-1];
        end
      end
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_d[0] <= wgt_in[c*DATA_W +: DATA_W];
          for (int i = 1; i < c; i++) r_d[i] <= r_d[i-1];
        end
      end
      assign w_pe_w[0][c]  = r_d[c-1];
      assign w_pe_wv[0][c] = r_v[c-1];
    end
  end

  // PE forwarding registers; the edge PEs have no neighbour to feed.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c < COLS - 1) begin : g_fwd_a
        logic [DATA_W-1:0] r_a;
        logic              r_av;
        always_ff @(posedge clk) begin
          if (rst)        r_av <= 1'b0;
          else if (w_adv) r_av <= w_pe_av[r][c];
        end
        always_ff @(posedge clk) begin
          if (w_adv) r_a <= w_pe_a[r][c];
        end
        assign w_pe_a[r][c+1]  = r_a;
        assign w_pe_av[r][c+1] = r_av;
      end
      if (r < ROWS - 1) begin : g_fwd_w
        logic [DATA_W-1:0] r_w;
        logic              r_wv;
        always_ff @(posedge clk) begin
          if (rst)        r_wv <= 1'b0;
          else if (w_adv) r_wv <= w_pe_wv[r][c];
        end
        always_ff @(posedge clk) begin
          if (w_adv) r_w <= w_pe_w[r][c];
        end
        assign w_pe_w[r+1][c]  = r_w;
        assign w_pe_wv[r+1][c] = r_wv;
      end
    end
  end

  function automatic logic [ACC_W-1:0] f_mac(input logic [ACC_W-1:0]  acc,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] w);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]      sum;
    prod = (2*DATA_W)'($signed(a)) * (2*DATA_W)'($signed(w));
    sum  = (ACC_W+1)'($signed(acc)) + (ACC_W+1)'(prod);
    // One guard bit is enough to see overflow of a two-operand signed add.
    if ((SATURATE != 0) && (sum[ACC_W] != sum[ACC_W-1]))
      return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return sum[ACC_W-1:0];
  endfunction

  logic [ACC_W-1:0] r_acc [ROWS][COLS];

  // Readout rotates each row left so column 0 always presents the current beat.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_acc[r][c] <= '0;
    end else if (w_shift_hs) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_acc[r][c] <= r_acc[r][(c + 1) % COLS];
    end else if (w_adv) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (w_pe_av[r][c] && w_pe_wv[r][c])
            r_acc[r][c] <= f_mac(r_acc[r][c], w_pe_a[r][c], w_pe_w[r][c]);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_out
    assign out_data[r*ACC_W +: ACC_W] = r_acc[r][0];
  end

endmodule

// File: tb/tb_systolic_array_os_param.sv
// Directed bench for systolic_array_os_param: 4x4 array at 24-bit accumulators,
// plus 16-bit saturating and wrapping copies driven by the same stimulus.
module tb_systolic_array_os_param;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int K_W    = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ROWS*DATA_W-1:0] act_in;
  logic                   act_valid;
  logic [COLS*DATA_W-1:0] wgt_in;
  logic                   wgt_valid;
  logic                   ctrl_start_valid;
  logic [K_W-1:0]         ctrl_inner_dim;
  logic                   ctrl_accumulate;
  logic                   out_ready;

  logic                   act_ready, wgt_ready, ctrl_start_ready;
  logic [ROWS*ACC_W-1:0]  out_data;
  logic                   out_valid, out_last, busy;
  logic [1:0]             dbg_state;

  logic                   s_act_ready, s_wgt_ready, s_start_ready, s_out_valid, s_out_last, s_busy;
  logic [ROWS*16-1:0]     s_out_data;
  logic [1:0]             s_dbg_state;
  logic                   w_act_ready, w_wgt_ready, w_start_ready, w_out_valid, w_out_last, w_busy;
  logic [ROWS*16-1:0]     w_out_data;
  logic [1:0]             w_dbg_state;

  systolic_array_os_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W),
                            .K_W(K_W), .SATURATE(0)) u_dut (
    .clk(clk), .rst(rst),
    .act_in(act_in), .act_valid(act_valid), .act_ready(act_ready),
    .wgt_in(wgt_in), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .ctrl_start_valid(ctrl_start_valid), .ctrl_start_ready(ctrl_start_ready),
    .ctrl_inner_dim(ctrl_inner_dim), .ctrl_accumulate(ctrl_accumulate),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .o_dbg_state(dbg_state)
  );

  systolic_array_os_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(16),
                            .K_W(K_W), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst),
    .act_in(act_in), .act_valid(act_valid), .act_ready(s_act_ready),
    .wgt_in(wgt_in), .wgt_valid(wgt_valid), .wgt_ready(s_wgt_ready),
    .ctrl_start_valid(ctrl_start_valid), .ctrl_start_ready(s_start_ready),
    .ctrl_inner_dim(ctrl_inner_dim), .ctrl_accumulate(ctrl_accumulate),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_last(s_out_last), .busy(s_busy), .o_dbg_state(s_dbg_state)
  );

  systolic_array_os_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(16),
                            .K_W(K_W), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst),
    .act_in(act_in), .act_valid(act_valid), .act_ready(w_act_ready),
    .wgt_in(wgt_in), .wgt_valid(wgt_valid), .wgt_ready(w_wgt_ready),
    .ctrl_start_valid(ctrl_start_valid), .ctrl_start_ready(w_start_ready),
    .ctrl_inner_dim(ctrl_inner_dim), .ctrl_accumulate(ctrl_accumulate),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_last(w_out_last), .busy(w_busy), .o_dbg_state(w_dbg_state)
  );

  // scoreboard
  logic [ACC_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic start_run(input int k, input bit accum);
    @(negedge clk);
    #1;
    check("start_ready", ctrl_start_ready, 1);
    ctrl_start_valid = 1'b1;
    ctrl_inner_dim   = K_W'(k);
    ctrl_accumulate  = accum;
    @(negedge clk);
    ctrl_start_valid = 1'b0;
  endtask

  task automatic feed(input int k, input logic [31:0] a, input logic [31:0] w, input bit sparse);
    act_in = a;
    wgt_in = w;
    for (int i = 0; i < k; i++) begin
      if (sparse) begin
        @(negedge clk);
        act_valid = 1'b1; wgt_valid = 1'b0;
        #1;
        check("act_only_act_ready", act_ready, 0);
        check("act_only_wgt_ready", wgt_ready, 0);
        @(negedge clk);
        act_valid = 1'b0; wgt_valid = 1'b0;
        #1;
        check("no_valid_act_ready", act_ready, 0);
      end
      @(negedge clk);
      act_valid = 1'b1; wgt_valid = 1'b1;
      #1;
      check("joint_act_ready", act_ready, 1);
      check("joint_wgt_ready", wgt_ready, 1);
    end
    @(negedge clk);
    act_valid = 1'b0; wgt_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [6:0] pat, input int plen,
                       input bit poke_start, input bit chk16, input int sat_exp, input int wrap_exp);
    int beats, vcyc, guard;
    beats = 0; vcyc = 0; guard = 0;
    while (beats < COLS && guard < 200) begin
      @(negedge clk);
      guard++;
      ctrl_start_valid = 1'b0;
      if (out_valid) begin
        out_ready = (vcyc < plen) ? pat[vcyc] : 1'b1;
        if (poke_start && !out_ready) begin
          ctrl_start_valid = 1'b1;
          ctrl_inner_dim   = '0;
          ctrl_accumulate  = 1'b0;
        end
        #1;
        if (poke_start && !out_ready) check({tag, "_start_ready_busy"}, ctrl_start_ready, 0);
        for (int r = 0; r < ROWS; r++)
          check({tag, "_lane"}, out_data[r*ACC_W +: ACC_W], exp_q[r]);
        check({tag, "_last"}, out_last, (beats == COLS - 1) ? 1 : 0);
        if (chk16) begin
          for (int r = 0; r < ROWS; r++) begin
            check({tag, "_sat_lane"}, int'($signed(s_out_data[r*16 +: 16])), sat_exp);
            check({tag, "_wrap_lane"}, int'($signed(w_out_data[r*16 +: 16])), wrap_exp);
          end
        end
        if (out_ready) begin
          repeat (ROWS) void'(exp_q.pop_front());
          beats++;
        end
        vcyc++;
      end
    end
    if (beats < COLS) check({tag, "_drain_timeout"}, beats, COLS);
    @(negedge clk);
    ctrl_start_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, out_valid, 0);
    check({tag, "_idle_state"}, dbg_state, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    act_in = '0; wgt_in = '0;
    act_valid = 1'b1; wgt_valid = 1'b1;
    ctrl_start_valid = 1'b0; ctrl_inner_dim = '0; ctrl_accumulate = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_start_ready", ctrl_start_ready, 1);
    check("rst_act_ready", act_ready, 0);
    check("rst_wgt_ready", wgt_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0; act_valid = 1'b0; wgt_valid = 1'b0;

    // K=1, act all 1, wgt lane c = c+1: beat b lanes = b+1
    for (int b = 0; b < COLS; b++) for (int r = 0; r < ROWS; r++) exp_q.push_back(ACC_W'(b + 1));
    start_run(1, 1'b0);
    feed(1, 32'h01010101, 32'h04030201, 1'b0);
    drain("k1", 7'h7f, 0, 1'b0, 1'b0, 0, 0);

    // same again accumulating: 2*(b+1)
    for (int b = 0; b < COLS; b++) for (int r = 0; r < ROWS; r++) exp_q.push_back(ACC_W'(2 * (b + 1)));
    start_run(1, 1'b1);
    feed(1, 32'h01010101, 32'h04030201, 1'b0);
    drain("k1_acc", 7'h7f, 0, 1'b0, 1'b0, 0, 0);

    // K=0 with clear: all zero
    for (int i = 0; i < ROWS * COLS; i++) exp_q.push_back('0);
    start_run(0, 1'b0);
    drain("k0_clr", 7'h7f, 0, 1'b0, 1'b0, 0, 0);

    // K=3, act lane r = r+1, wgt 2, sparse valids: C[r][c] = 6*(r+1)
    for (int b = 0; b < COLS; b++) for (int r = 0; r < ROWS; r++) exp_q.push_back(ACC_W'(6 * (r + 1)));
    start_run(3, 1'b0);
    feed(3, 32'h04030201, 32'h02020202, 1'b1);
    drain("k3_sparse", 7'h7f, 0, 1'b0, 1'b0, 0, 0);

    // 127*127*3 = 48387: saturates to 32767 at 16 bits, wraps to -17149
    for (int i = 0; i < ROWS * COLS; i++) exp_q.push_back(ACC_W'(48387));
    start_run(3, 1'b0);
    feed(3, 32'h7f7f7f7f, 32'h7f7f7f7f, 1'b0);
    drain("sat", 7'h7f, 0, 1'b0, 1'b1, 32767, -17149);

    // readout with out_ready 1,0,0,1,0,1,1 and start pokes while busy
    for (int b = 0; b < COLS; b++) for (int r = 0; r < ROWS; r++) exp_q.push_back(ACC_W'(b + 1));
    start_run(1, 1'b0);
    feed(1, 32'h01010101, 32'h04030201, 1'b0);
    drain("stall", 7'b1101001, 7, 1'b1, 1'b0, 0, 0);

    // reset after 2 of 5 beats, then accumulate-mode K=1 of ones sees cleared state
    start_run(5, 1'b0);
    feed(2, 32'h05050505, 32'h05050505, 1'b0);
    #1;
    check("midload_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_start_ready", ctrl_start_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < ROWS * COLS; i++) exp_q.push_back(ACC_W'(1));
    start_run(1, 1'b1);
    feed(1, 32'h01010101, 32'h01010101, 1'b0);
    drain("post_rst", 7'h7f, 0, 1'b0, 1'b0, 0, 0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
